// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
//   csa_nstg()   : number of pipeline stages (latency in cycles) from the widths.
//   op_e         : operation encoding carried on the Sub input.
//   stage_ctrl_t : per-stage control fields (valid, resolved carry, Sub, Sat, OVF).
//                  The width-dependent fields (remaining A/B and partial Sum) are
//                  appended inside the top module, where WIDTH is known.
package csa_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic valid;
        logic carry;   // carry into the first segment of the next stage
        logic sub;
        logic sat;
        logic ovf;     // meaningful only after the last stage
    } stage_ctrl_t;

    // Latency in cycles: one stage per BLOCKS_PER_STAGE segments.
    function automatic int csa_nstg(input int width, input int block, input int bps);
        return (width / block) / bps;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select segment: two BLOCK-bit ripple adders, one assuming
// carry-in 0 and one assuming carry-in 1.
// Ports:
//   a, b       : segment operand bits (b already inverted for subtraction)
//   sum0, sum1 : segment sums for carry-in 0 / 1
//   c0, c1     : segment carry-out for carry-in 0 / 1
//   cm0, cm1   : carry into the segment MSB for carry-in 0 / 1 (signed overflow)
module csa_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    output logic [BLOCK-1:0] sum0,
    output logic [BLOCK-1:0] sum1,
    output logic             c0,
    output logic             c1,
    output logic             cm0,
    output logic             cm1
);

    // Dual ripple chain, both carry-in assumptions evaluated in parallel.
    always_comb begin
        logic [BLOCK:0] r0_v;
        logic [BLOCK:0] r1_v;
        r0_v    = {(BLOCK+1){1'b0}};
        r1_v    = {(BLOCK+1){1'b0}};
        sum0    = {BLOCK{1'b0}};
        sum1    = {BLOCK{1'b0}};
        r0_v[0] = 1'b0;
        r1_v[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i]   = a[i] ^ b[i] ^ r0_v[i];
            r0_v[i+1] = (a[i] & b[i]) | (a[i] & r0_v[i]) | (b[i] & r0_v[i]);
            sum1[i]   = a[i] ^ b[i] ^ r1_v[i];
            r1_v[i+1] = (a[i] & b[i]) | (a[i] & r1_v[i]) | (b[i] & r1_v[i]);
        end
        c0  = r0_v[BLOCK];
        c1  = r1_v[BLOCK];
        cm0 = r0_v[BLOCK-1];
        cm1 = r1_v[BLOCK-1];
    end

endmodule

// File: rtl/pipelined_cs_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready handshakes.
// Operands are captured into stage register 0; each following clock resolves
// BLOCKS_PER_STAGE segments and registers the resolved carry, so the result
// appears NSTG cycles after acceptance, with Sum/CO/OVF aligned.
// Optional feature macro: CSA_SAT_EN (adds the Sat input; signed saturation
// applied in the final stage).
// Ports:
//   Clk, Reset          : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  : operand-side handshake
//   A, B, c_in, Sub     : operands, carry/borrow-in, 0=add 1=subtract
//   Sat (CSA_SAT_EN)    : clamp on signed overflow
//   out_valid, out_ready: result-side handshake
//   Sum, CO, OVF        : result, raw carry out, signed overflow
module pipelined_cs_adder
    import csa_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int BLOCK            = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic             Sub,
`ifdef CSA_SAT_EN
    input  logic             Sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             OVF
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int BPS  = BLOCKS_PER_STAGE;
    localparam int NSTG = csa_nstg(WIDTH, BLOCK, BLOCKS_PER_STAGE);

    localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // a keeps the original A (its MSB selects the saturation direction);
    // b is already inverted for subtraction.
    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t           pipe_r [NSTG+1];
    stage_t           capt_s;
    stage_t           next_s [NSTG];
    logic             advance_s;
    logic             sat_in_s;

    logic [BLOCK-1:0] blk_sum0_s [NBLK];
    logic [BLOCK-1:0] blk_sum1_s [NBLK];
    logic [NBLK-1:0]  blk_c0_s;
    logic [NBLK-1:0]  blk_c1_s;
    logic [NBLK-1:0]  blk_cm0_s;
    logic [NBLK-1:0]  blk_cm1_s;

`ifdef CSA_SAT_EN
    assign sat_in_s = Sat;
`else
    assign sat_in_s = 1'b0;
`endif

    // The whole pipe moves together; a stalled output freezes every stage.
    assign advance_s = ~pipe_r[NSTG].ctrl.valid | out_ready;
    assign in_ready  = advance_s;

    assign out_valid = pipe_r[NSTG].ctrl.valid;
    assign Sum       = pipe_r[NSTG].sum;
    assign CO        = pipe_r[NSTG].ctrl.carry;
    assign OVF       = pipe_r[NSTG].ctrl.ovf;

    // Segment i is evaluated from the stage register that owns it.
    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        csa_block #(.BLOCK(BLOCK)) u_blk (
            .a    (pipe_r[i/BPS].a[i*BLOCK +: BLOCK]),
            .b    (pipe_r[i/BPS].b[i*BLOCK +: BLOCK]),
            .sum0 (blk_sum0_s[i]),
            .sum1 (blk_sum1_s[i]),
            .c0   (blk_c0_s[i]),
            .c1   (blk_c1_s[i]),
            .cm0  (blk_cm0_s[i]),
            .cm1  (blk_cm1_s[i])
        );
    end

    // Operand capture: subtraction becomes A + ~B + !c_in. Data only loads
    // on a valid operand set; a bubble just clears the valid bit.
    always_comb begin
        capt_s            = pipe_r[0];
        capt_s.ctrl.valid = in_valid;
        if (in_valid) begin
            capt_s.a        = A;
            capt_s.sum      = {WIDTH{1'b0}};
            capt_s.ctrl.sat = sat_in_s;
            capt_s.ctrl.ovf = 1'b0;
            case (op_e'(Sub))
                OP_SUB: begin
                    capt_s.b        = ~B;
                    capt_s.ctrl.carry = ~c_in;
                    capt_s.ctrl.sub = 1'b1;
                end
                default: begin
                    capt_s.b        = B;
                    capt_s.ctrl.carry = c_in;
                    capt_s.ctrl.sub = 1'b0;
                end
            endcase
        end else begin
            capt_s.ctrl.valid = 1'b0;
        end
    end

    // Per-stage carry select: carry_out = c0 | (c1 & cin) across the stage's
    // segments; the last stage also derives OVF and applies saturation.
    always_comb begin
        logic [BPS:0] cc_v;
        logic         msb_c_v;
        int           idx_v;
        cc_v    = {(BPS+1){1'b0}};
        msb_c_v = 1'b0;
        idx_v   = 0;
        for (int s = 0; s < NSTG; s++) begin
            next_s[s] = pipe_r[s];
            cc_v      = {(BPS+1){1'b0}};
            cc_v[0]   = pipe_r[s].ctrl.carry;
            for (int j = 0; j < BPS; j++) begin
                idx_v     = s * BPS + j;
                cc_v[j+1] = blk_c0_s[idx_v] | (blk_c1_s[idx_v] & cc_v[j]);
                next_s[s].sum[idx_v*BLOCK +: BLOCK] =
                    cc_v[j] ? blk_sum1_s[idx_v] : blk_sum0_s[idx_v];
            end
            next_s[s].ctrl.carry = cc_v[BPS];
            if (s == NSTG - 1) begin
                // Carry into the MSB comes from the top segment, selected by its own carry-in.
                msb_c_v = cc_v[BPS-1] ? blk_cm1_s[NBLK-1] : blk_cm0_s[NBLK-1];
                next_s[s].ctrl.ovf = msb_c_v ^ cc_v[BPS];
`ifdef CSA_SAT_EN
                if (pipe_r[s].ctrl.sat && next_s[s].ctrl.ovf) begin
                    next_s[s].sum = pipe_r[s].a[WIDTH-1] ? SIGNED_MIN : SIGNED_MAX;
                end else begin
                    next_s[s].sum = next_s[s].sum;
                end
`endif
            end else begin
                next_s[s].ctrl.ovf = 1'b0;
            end
        end
    end

    // Stage registers: cleared on reset, shifted together on advance, held otherwise.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k <= NSTG; k++) begin
                pipe_r[k] <= '0;
            end
        end else if (advance_s) begin
            pipe_r[0] <= capt_s;
            for (int s = 0; s < NSTG; s++) begin
                pipe_r[s+1] <= next_s[s];
            end
        end
    end

endmodule
